// File: rtl/spi_sub_rx_if.sv
// spi_sub_rx_if: SPI subordinate receiver bus; master drives sclk/mosi/csb, slave returns frame payload, strobes and busy
interface spi_sub_rx_if #(
  parameter int WORD_WIDTH = 16
);
  logic sclk;
  logic mosi;
  logic csb;
  logic [WORD_WIDTH-1:0] data_out;
  logic [1:0] power_state_out;
  logic data_valid;
  logic frame_err;
  logic busy;
  modport master (
    output sclk, mosi, csb,
    input data_out, power_state_out, data_valid, frame_err, busy
  );
  modport slave (
    input sclk, mosi, csb,
    output data_out, power_state_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_sub_rx.sv
// spi_sub_rx: SPI subordinate frame receiver; sys_clk/rst_n plus bus (sclk, mosi, csb in; data_out, power_state_out, data_valid, frame_err, busy out)
module spi_sub_rx #(
  parameter int WORD_WIDTH = 16
) (
  input logic sys_clk,
  input logic rst_n,
  spi_sub_rx_if.slave bus
);
  localparam int FRAME_WIDTH = WORD_WIDTH + 2;
  localparam int CW = $clog2(FRAME_WIDTH + 2);
  localparam logic [CW-1:0] FULL = CW'(FRAME_WIDTH);
  localparam logic [CW-1:0] SAT = CW'(FRAME_WIDTH + 1);
  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e state_q, state_d;
  logic [2:0] sclk_q, sclk_d, mosi_q, mosi_d, csb_q, csb_d;
  logic sclk_fall_q, sclk_fall_d, csb_fall_q, csb_fall_d, csb_rise_q, csb_rise_d;
  logic end_q, end_d;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [1:0] ps_q, ps_d;
  logic dv_q, dv_d, fe_q, fe_d, busy_q, busy_d;
  always_comb begin
    sclk_d = {sclk_q[1:0], bus.sclk};
    mosi_d = {mosi_q[1:0], bus.mosi};
    csb_d = {csb_q[1:0], bus.csb};
    sclk_fall_d = sclk_q[2] & ~sclk_q[1];
    csb_fall_d = csb_q[2] & ~csb_q[1];
    csb_rise_d = ~csb_q[2] & csb_q[1];
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    end_d = 1'b0;
    if (state_q == IDLE) begin
      if (csb_fall_q) begin
        state_d = ACTIVE;
        shift_d = '0;
        cnt_d = '0;
      end
    end else begin
      if (sclk_fall_q && cnt_q < FULL) shift_d = {shift_q[FRAME_WIDTH-2:0], mosi_q[2]};
      if (sclk_fall_q && cnt_q != SAT) cnt_d = cnt_q + 1'b1;
      if (csb_rise_q) begin
        state_d = IDLE;
        end_d = 1'b1;
      end
    end
  end
  always_comb begin
    dv_d = end_q && cnt_q == FULL;
    fe_d = end_q && cnt_q != FULL;
    data_d = dv_d ? shift_q[WORD_WIDTH-1:0] : data_q;
    ps_d = dv_d ? shift_q[FRAME_WIDTH-1 -: 2] : ps_q;
    busy_d = state_d == ACTIVE;
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b111;
      mosi_q <= '0;
      csb_q <= '0;
      sclk_fall_q <= 1'b0;
      csb_fall_q <= 1'b0;
      csb_rise_q <= 1'b0;
      end_q <= 1'b0;
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      ps_q <= '0;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      csb_q <= csb_d;
      sclk_fall_q <= sclk_fall_d;
      csb_fall_q <= csb_fall_d;
      csb_rise_q <= csb_rise_d;
      end_q <= end_d;
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      ps_q <= ps_d;
      dv_q <= dv_d;
      fe_q <= fe_d;
      busy_q <= busy_d;
    end
  end
  assign bus.data_out = data_q;
  assign bus.power_state_out = ps_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err = fe_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_spi_sub_rx.sv
// tb_spi_sub_rx: directed self-checking bench for spi_sub_rx at sys_clk:sclk = 4:1
module tb_spi_sub_rx;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int fails = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  logic dv_prev = 1'b0;
  logic fe_prev = 1'b0;
  int mark_dv, mark_fe;
  spi_sub_rx_if #(.WORD_WIDTH(16)) bus ();
  spi_sub_rx #(.WORD_WIDTH(16)) dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  always @(negedge sys_clk) begin
    if (bus.data_valid) dv_cnt <= dv_cnt + 1;
    if (bus.frame_err) fe_cnt <= fe_cnt + 1;
    if (bus.data_valid && bus.frame_err) both_cnt <= both_cnt + 1;
    if ((bus.data_valid && dv_prev) || (bus.frame_err && fe_prev)) long_cnt <= long_cnt + 1;
    dv_prev <= bus.data_valid;
    fe_prev <= bus.frame_err;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start();
    bus.csb = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("busy_rise", 32'(bus.busy), 32'd1);
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = v[i];
      repeat (2) @(negedge sys_clk);
      bus.sclk = 1'b0;
      repeat (2) @(negedge sys_clk);
      bus.sclk = 1'b1;
    end
  endtask
  task automatic finish(input logic good, input logic [15:0] d, input logic [1:0] p);
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    bus.csb = 1'b1;
    repeat (2) @(negedge sys_clk);
    bus.sclk = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("pre_dv", 32'(bus.data_valid), 32'd0);
    check("pre_fe", 32'(bus.frame_err), 32'd0);
    @(negedge sys_clk);
    check("dv", 32'(bus.data_valid), 32'(good));
    check("fe", 32'(bus.frame_err), 32'(!good));
    check("data", 32'(bus.data_out), 32'(d));
    check("ps", 32'(bus.power_state_out), 32'(p));
    check("busy_fall", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge sys_clk);
    check("dv_count", 32'(dv_cnt - dv0), 32'(good));
    check("fe_count", 32'(fe_cnt - fe0), 32'(!good));
  endtask
  initial begin
    bus.sclk = 1'b1;
    bus.mosi = 1'b0;
    bus.csb = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_ps", 32'(bus.power_state_out), 32'd0);
    check("rst_dv", 32'(bus.data_valid), 32'd0);
    check("rst_fe", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    start();
    send(32'h2A5C3, 18);
    finish(1'b1, 16'hA5C3, 2'b10);
    start();
    send(32'h11234, 18);
    finish(1'b1, 16'h1234, 2'b01);
    start();
    send(32'h1FFFF, 17);
    finish(1'b0, 16'h1234, 2'b01);
    start();
    send(32'h7FFFF, 19);
    repeat (3) @(negedge sys_clk);
    check("cnt_19", 32'(dut.cnt_q), 32'd19);
    send(32'h3, 2);
    repeat (3) @(negedge sys_clk);
    check("cnt_sat", 32'(dut.cnt_q), 32'd19);
    finish(1'b0, 16'h1234, 2'b01);
    start();
    send(32'h1AB, 9);
    mark_dv = dv_cnt;
    mark_fe = fe_cnt;
    rst_n = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_data", 32'(bus.data_out), 32'd0);
    check("mid_rst_ps", 32'(bus.power_state_out), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    send(32'h1CD, 9);
    bus.csb = 1'b1;
    repeat (8) @(negedge sys_clk);
    check("abort_dv_count", 32'(dv_cnt - mark_dv), 32'd0);
    check("abort_fe_count", 32'(fe_cnt - mark_fe), 32'd0);
    check("abort_data", 32'(bus.data_out), 32'd0);
    check("abort_ps", 32'(bus.power_state_out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    start();
    send(32'h3FFFF, 18);
    finish(1'b1, 16'hFFFF, 2'b11);
    start();
    send(32'h00001, 18);
    bus.csb = 1'b1;
    repeat (3) @(negedge sys_clk);
    bus.csb = 1'b0;
    @(negedge sys_clk);
    check("b2b_gap_busy", 32'(bus.busy), 32'd0);
    check("b2b_pre_dv", 32'(bus.data_valid), 32'd0);
    @(negedge sys_clk);
    check("b2b_dv1", 32'(bus.data_valid), 32'd1);
    check("b2b_data1", 32'(bus.data_out), 32'h0001);
    check("b2b_ps1", 32'(bus.power_state_out), 32'd0);
    repeat (2) @(negedge sys_clk);
    check("b2b_busy2", 32'(bus.busy), 32'd1);
    send(32'h18000, 18);
    finish(1'b1, 16'h8000, 2'b01);
    start();
    send(32'h0AD1E, 17);
    bus.mosi = 1'b0;
    repeat (2) @(negedge sys_clk);
    bus.sclk = 1'b0;
    finish(1'b1, 16'h5A3C, 2'b01);
    check("pulse_overlap", 32'(both_cnt), 32'd0);
    check("pulse_width", 32'(long_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
